l2_line_read_responder: RTL
===========================

// Module: l2_line_read_responder
// PURPOSE
// - Responder end of the L1 line-read protocol: serves 512-bit line fills requested by L1_I (L2_S_R_* side).
// - Issues one line-aligned burst on a narrow memory read port and assembles the beats into a line buffer.
// - Returns the full line with a single-cycle valid pulse. Sits between the L1 instruction cache and memory.
// PARAMETERS
// - BYTES_PER_LINE  64  line size in bytes; must be a power of 2 and >= BEAT_BYTES
// - BEAT_BYTES      8   memory data beat width in bytes; must divide BYTES_PER_LINE
// - OFFSET_SIZE     $clog2(BYTES_PER_LINE)  line offset bits
// - BEATS           BYTES_PER_LINE/BEAT_BYTES  beats per line (8)
// - DATA_SIZE       BYTES_PER_LINE*8  line width in bits (512)
// PORTS
// - clk               in   1          clock; all logic on posedge
// - reset             in   1          asynchronous, active-high reset
// - S_R_ADDR          in   64         requested byte address from L1; offset bits ignored
// - S_R_ADDR_VALID    in   1          request level; held high by L1 until S_R_DATA_VALID
// - S_R_DATA          out  DATA_SIZE  returned line; byte k at bits [8k+7:8k]
// - S_R_DATA_VALID    out  1          one-cycle pulse: S_R_DATA holds the requested line
// - MEM_R_ADDR        out  64         line-aligned burst address (offset bits forced to 0)
// - MEM_R_ADDR_VALID  out  1          burst request; held until MEM_R_ADDR_READY
// - MEM_R_ADDR_READY  in   1          memory accepts burst when VALID&&READY at posedge
// - MEM_R_DATA        in   BEAT_BYTES*8  data beat
// - MEM_R_DATA_VALID  in   1          beat valid; exactly BEATS beats per accepted burst, in address order
// BEHAVIOUR
// - Reset (async, active-high): state=IDLE; S_R_DATA=0, S_R_DATA_VALID=0, MEM_R_ADDR=0, MEM_R_ADDR_VALID=0; beat_cnt=0.
// - All outputs are registered.
// - FSM states and transitions:
//   - IDLE: on S_R_ADDR_VALID, latch S_R_ADDR (line-aligned) and go to ADDR.
//   - ADDR: drive MEM_R_ADDR and MEM_R_ADDR_VALID=1. On READY, drop VALID next cycle, clear beat_cnt, go to FILL.
//   - FILL: each MEM_R_DATA_VALID writes the beat to line[beat_cnt*BEAT_BYTES*8 +: BEAT_BYTES*8] and increments beat_cnt.
//     On beat BEATS-1 go to RESP. beat_cnt is $clog2(BEATS) bits and is never allowed to wrap within a burst.
//   - RESP: S_R_DATA<=line; S_R_DATA_VALID pulses for exactly 1 cycle. Always go to GAP.
//   - GAP: 1 cycle; S_R_ADDR_VALID is ignored so the still-high L1 request is not re-served; go to IDLE.
// - Miss latency: request seen at edge N -> MEM_R_ADDR_VALID at N+1. Last beat at edge M -> S_R_DATA_VALID high in cycle M+1.
// - S_R_DATA holds its value until the next response; it is not cleared when S_R_DATA_VALID drops.
// - S_R_ADDR changing while a request is in flight: ignored; the latched address is used.
// - Requester drops S_R_ADDR_VALID before RESP: the burst still completes (all BEATS consumed).
//   The response pulse is suppressed (S_R_DATA_VALID stays 0); the line buffer still updates.
// - MEM_R_DATA_VALID outside FILL (e.g. stray beats after a reset mid-burst): discarded, no state change.
// - Reset mid-operation: returns to IDLE immediately; partial line discarded; no response issued.
// - Simultaneous last beat and requester drop: the beat is accepted; the response is suppressed per the rule above.
// CONFIGURATION
// - LAST_LINE_BUFFER_EN defined:
//   - Keeps {buf_valid, buf_tag=addr[63:OFFSET_SIZE]} for the last fully filled line; buf_valid=0 on reset.
//   - IDLE request whose tag matches buf_tag with buf_valid=1: go directly to RESP. Pulse appears the cycle after the request is seen; no memory traffic.
//   - buf_valid is set on every completed fill, including suppressed ones.
// - LAST_LINE_BUFFER_EN undefined: no tag/valid storage; every request performs a full memory burst.
// TESTING
// - Reset: assert reset asynchronously mid-cycle -> all outputs 0 before the next posedge; deassert -> IDLE, no MEM_R_ADDR_VALID.
// - Miss: S_R_ADDR=0x1000_0047, memory READY after 2 cycles, beats 0x0..0x7 back-to-back.
//   -> MEM_R_ADDR=0x1000_0040; S_R_DATA[63:0]=0x0 and [511:448]=0x7; exactly one 1-cycle S_R_DATA_VALID.
// - Held request: L1 keeps S_R_ADDR_VALID high 1 cycle past the pulse -> no second burst; GAP absorbs it.
// - Gapped beats: insert 3 idle cycles between beats 3 and 4 -> line still assembled in order, single pulse after beat 7.
// - Dropped request: deassert S_R_ADDR_VALID during FILL -> 8 beats consumed, S_R_DATA_VALID never asserted, next request served normally.
// - LAST_LINE_BUFFER_EN: after the fill of 0x1000_0040, request 0x1000_0068 -> pulse 1 cycle later with identical line, MEM_R_ADDR_VALID stays 0.
//   Same test with macro undefined -> full burst to 0x1000_0040.

Source files
------------

// File: rtl/l2_line_read_responder.sv
`default_nettype none
// ============================================================================
// Module      : l2_line_read_responder
// Description : Serves L1 line-read requests with one line-aligned memory burst
//               and returns the assembled line with a one-cycle valid pulse.
//               Optional macro LAST_LINE_BUFFER_EN re-serves the last filled line.
// Revision    : 1.0 - initial release
// ============================================================================
module l2_line_read_responder #(
   parameter int BYTES_PER_LINE = 64,
   parameter int BEAT_BYTES     = 8,
   parameter int OFFSET_SIZE    = $clog2(BYTES_PER_LINE),
   parameter int BEATS          = BYTES_PER_LINE / BEAT_BYTES,
   parameter int DATA_SIZE      = BYTES_PER_LINE * 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [63:0]             S_R_ADDR,
   input  logic                    S_R_ADDR_VALID,
   output logic [DATA_SIZE-1:0]    S_R_DATA,
   output logic                    S_R_DATA_VALID,
   output logic [63:0]             MEM_R_ADDR,
   output logic                    MEM_R_ADDR_VALID,
   input  logic                    MEM_R_ADDR_READY,
   input  logic [BEAT_BYTES*8-1:0] MEM_R_DATA,
   input  logic                    MEM_R_DATA_VALID
);

   localparam int          c_beat_w    = BEAT_BYTES * 8;
   localparam int          c_cnt_w     = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [63:0] c_addr_mask = ~64'(BYTES_PER_LINE - 1);
   localparam logic [c_cnt_w-1:0] c_last_beat = c_cnt_w'(BEATS - 1);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ADDR = 3'd1,
      ST_FILL = 3'd2,
      ST_RESP = 3'd3,
      ST_GAP  = 3'd4
   } state_t;

   state_t                 r_state;
   state_t                 w_state_next;
   logic [c_cnt_w-1:0]     r_beat_cnt;
   logic [DATA_SIZE-1:0]   r_line;
   logic [DATA_SIZE-1:0]   w_line_next;
   logic                   r_dropped;
   logic [63:0]            w_aligned;
   logic                   w_hit_cond;
   logic                   w_launch;
   logic                   w_hit;
   logic                   w_accept;
   logic                   w_beat_wr;
   logic                   w_fill_done;
   logic                   w_suppress;

   assign w_aligned  = S_R_ADDR & c_addr_mask;
   // A drop seen earlier, or coincident with the last beat, cancels the pulse.
   assign w_suppress = r_dropped | ~S_R_ADDR_VALID;

`ifdef LAST_LINE_BUFFER_EN
   logic                    r_buf_valid;
   logic [63-OFFSET_SIZE:0] r_buf_tag;

   assign w_hit_cond = r_buf_valid && (w_aligned[63:OFFSET_SIZE] == r_buf_tag);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_buf_valid <= 1'b0;
         r_buf_tag   <= '0;
      end else if (w_fill_done) begin
         r_buf_valid <= 1'b1;
         r_buf_tag   <= MEM_R_ADDR[63:OFFSET_SIZE];
      end
   end
`else
   assign w_hit_cond = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_launch     = 1'b0;
      w_hit        = 1'b0;
      w_accept     = 1'b0;
      w_beat_wr    = 1'b0;
      w_fill_done  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (S_R_ADDR_VALID) begin
               if (w_hit_cond) begin
                  w_hit        = 1'b1;
                  w_state_next = ST_RESP;
               end else begin
                  w_launch     = 1'b1;
                  w_state_next = ST_ADDR;
               end
            end
         end
         ST_ADDR: begin
            if (MEM_R_ADDR_READY) begin
               w_accept     = 1'b1;
               w_state_next = ST_FILL;
            end
         end
         ST_FILL: begin
            if (MEM_R_DATA_VALID) begin
               w_beat_wr = 1'b1;
               if (r_beat_cnt == c_last_beat) begin
                  w_fill_done  = 1'b1;
                  w_state_next = ST_RESP;
               end
            end
         end
         ST_RESP: w_state_next = ST_GAP;
         ST_GAP:  w_state_next = ST_IDLE;
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      w_line_next = r_line;
      for (int b = 0; b < BEATS; b++) begin
         if (c_cnt_w'(b) == r_beat_cnt) begin
            w_line_next[b*c_beat_w +: c_beat_w] = MEM_R_DATA;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         S_R_DATA         <= '0;
         S_R_DATA_VALID   <= 1'b0;
         MEM_R_ADDR       <= '0;
         MEM_R_ADDR_VALID <= 1'b0;
         r_beat_cnt       <= '0;
         r_line           <= '0;
         r_dropped        <= 1'b0;
      end else begin
         S_R_DATA_VALID <= 1'b0;
         if (w_launch) begin
            MEM_R_ADDR       <= w_aligned;
            MEM_R_ADDR_VALID <= 1'b1;
            r_dropped        <= 1'b0;
         end
         if (w_accept) begin
            MEM_R_ADDR_VALID <= 1'b0;
            r_beat_cnt       <= '0;
         end
         if (((r_state == ST_ADDR) || (r_state == ST_FILL)) && !S_R_ADDR_VALID) begin
            r_dropped <= 1'b1;
         end
         if (w_beat_wr) begin
            r_line <= w_line_next;
            if (!w_fill_done) r_beat_cnt <= r_beat_cnt + c_cnt_w'(1);
         end
         if (w_fill_done && !w_suppress) begin
            S_R_DATA       <= w_line_next;
            S_R_DATA_VALID <= 1'b1;
         end
         if (w_hit) begin
            S_R_DATA       <= r_line;
            S_R_DATA_VALID <= 1'b1;
         end
      end
   end

endmodule
`default_nettype wire
